// File: rtl/uart_rx_cfg_pkg.sv
// Shared encodings and helpers for the configurable UART receiver (and a later transmitter).
package uart_rx_cfg_pkg;

  // Parity selection; 2'b11 also means no parity.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP1     = 3'd4,
    STOP2     = 3'd5,
    WAIT_HIGH = 3'd6
  } rx_state_t;

  typedef struct packed {
    logic perr;
    logic ferr;
    logic brk;
  } rx_flags_t;

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode != PAR_NONE) && (mode != 2'b11);
  endfunction

  function automatic logic majority3(input logic [2:0] h);
    return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_sync_vote.sv
// Two-flop synchroniser for the serial line followed by a 3-sample majority vote.
module uart_rx_cfg_sync_vote
  import uart_rx_cfg_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic signal_in,
  output logic s,
  output logic v,
  output logic fall
);

  logic       sync1_q;
  logic       sync2_q;
  logic [2:0] hist_q;

  // Synchroniser and history shift; everything idles high so reset never looks like a start.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
    end else begin
      sync1_q <= signal_in;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[1:0], sync2_q};
    end
  end

  assign s    = sync2_q;
  assign v    = majority3(hist_q);
  // hist_q[0] is the previous value of s.
  assign fall = hist_q[0] & ~sync2_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1 or 2 stop bits,
// break/framing/parity reporting and a one-entry valid/ready holding register.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PRESC_W-1:0] prescaler_max,
  input  logic [1:0]         parity_mode,
  input  logic               stop2,
  input  logic               signal_in,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [DATA_W-1:0]  data_out,
  output logic               perr_out,
  output logic               ferr_out,
  output logic               brk_out,
  output logic               ovr_out,
  output logic               busy_out
);

  localparam int unsigned IdxW = (DATA_W > 8) ? 4 : 3;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

  logic line_s;
  logic line_v;
  logic line_fall;

  uart_rx_cfg_sync_vote u_sync (
    .clock     (clock),
    .reset     (reset),
    .signal_in (signal_in),
    .s         (line_s),
    .v         (line_v),
    .fall      (line_fall)
  );

  rx_state_t          state_q, state_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_bit_q, par_bit_d;
  logic               perr_q, perr_d;
  logic [PRESC_W-1:0] sh_max_q, sh_max_d;
  logic [1:0]         sh_par_q, sh_par_d;
  logic               sh_stop2_q, sh_stop2_d;
  logic               done_q, done_d;
  rx_flags_t          fr_q, fr_d;

  logic sample;
  logic par_exp;

  assign sample  = (cnt_q == '0);
  assign par_exp = (sh_par_q == PAR_ODD) ? ~(^shift_q) : (^shift_q);

  // Frame FSM next-state: bit timing, shifting, parity and stop checks.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
    sh_max_d   = sh_max_q;
    sh_par_d   = sh_par_q;
    sh_stop2_d = sh_stop2_q;
    done_d     = 1'b0;
    fr_d       = fr_q;

    if (state_q != IDLE && state_q != WAIT_HIGH) begin
      cnt_d = sample ? sh_max_q : (cnt_q - PRESC_W'(1));
    end

    unique case (state_q)
      IDLE: begin
        if (line_fall) begin
          // Frame configuration is frozen here for the whole frame.
          sh_max_d   = prescaler_max;
          sh_par_d   = parity_mode;
          sh_stop2_d = stop2;
          cnt_d      = prescaler_max >> 1;
          state_d    = START;
        end
      end
      START: begin
        if (sample) begin
          if (line_v) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            idx_d     = '0;
            perr_d    = 1'b0;
            par_bit_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_d = {line_v, shift_q[DATA_W-1:1]};
          if (idx_q == LastIdx) begin
            state_d = parity_on(sh_par_q) ? PARITY : STOP1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      PARITY: begin
        if (sample) begin
          par_bit_d = line_v;
          perr_d    = (line_v != par_exp);
          state_d   = STOP1;
        end
      end
      STOP1: begin
        if (sample) begin
          if (line_v) begin
            if (sh_stop2_q) begin
              state_d = STOP2;
            end else begin
              done_d  = 1'b1;
              fr_d    = '{perr: perr_q, ferr: 1'b0, brk: 1'b0};
              state_d = IDLE;
            end
          end else begin
            done_d  = 1'b1;
            fr_d    = '{perr: perr_q, ferr: 1'b1,
                        brk: (shift_q == '0) && (!parity_on(sh_par_q) || !par_bit_q)};
            // Hold off start detection until the line has recovered.
            state_d = WAIT_HIGH;
          end
        end
      end
      STOP2: begin
        if (sample) begin
          done_d  = 1'b1;
          fr_d    = '{perr: perr_q, ferr: ~line_v, brk: 1'b0};
          state_d = line_v ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (line_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame FSM state registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      sh_max_q   <= '0;
      sh_par_q   <= PAR_NONE;
      sh_stop2_q <= 1'b0;
      done_q     <= 1'b0;
      fr_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
      sh_max_q   <= sh_max_d;
      sh_par_q   <= sh_par_d;
      sh_stop2_q <= sh_stop2_d;
      done_q     <= done_d;
      fr_q       <= fr_d;
    end
  end

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  rx_flags_t         flags_q;
  logic              ovr_q;

  // Holding register: load a completed frame if free (or draining now), else mark overrun.
  // shift_q is still intact one clock after completion, so it is loaded directly.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
      ovr_q   <= 1'b0;
    end else if (done_q) begin
      if (!valid_q || ready_in) begin
        valid_q <= 1'b1;
        data_q  <= shift_q;
        flags_q <= fr_q;
        ovr_q   <= 1'b0;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (valid_q && ready_in) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign perr_out  = flags_q.perr;
  assign ferr_out  = flags_q.ferr;
  assign brk_out   = flags_q.brk;
  assign ovr_out   = ovr_q;
  assign busy_out  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8-bit frames at 16 clocks per bit.
module tb_uart_rx_cfg;

  localparam int BIT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] prescaler_max;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        signal_in;
  logic        valid_out;
  logic        ready_in;
  logic [7:0]  data_out;
  logic        perr_out;
  logic        ferr_out;
  logic        brk_out;
  logic        ovr_out;
  logic        busy_out;

  uart_rx_cfg #(
    .DATA_W  (8),
    .PRESC_W (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .prescaler_max (prescaler_max),
    .parity_mode   (parity_mode),
    .stop2         (stop2),
    .signal_in     (signal_in),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .data_out      (data_out),
    .perr_out      (perr_out),
    .ferr_out      (ferr_out),
    .brk_out       (brk_out),
    .ovr_out       (ovr_out),
    .busy_out      (busy_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       ov;
    logic       bk;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } word_t;

  word_t words[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    cyc      = 0;
  int    vhigh    = 0;
  int    t_busy   = 0;
  int    t_valid  = 0;
  logic  busy_p   = 1'b0;
  logic  valid_p  = 1'b0;

  // Record every accepted word and the rise times of busy/valid.
  always @(negedge clock) begin
    #1;
    cyc++;
    if (busy_out && !busy_p) t_busy = cyc;
    if (valid_out && !valid_p) t_valid = cyc;
    if (valid_out) vhigh++;
    if (valid_out && ready_in) words.push_back({ovr_out, brk_out, ferr_out, perr_out, data_out});
    busy_p  = busy_out;
    valid_p = valid_out;
  end

  function automatic word_t get_word(input int i);
    if (i < words.size()) return words[i];
    return '0;
  endfunction

  function automatic word_t mk(input logic [7:0] d, input logic pe, input logic fe,
                               input logic bk, input logic ov);
    return {ov, bk, fe, pe, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    signal_in = b;
    repeat (BIT) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic st1, input logic has_st2, input logic st2);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(pbit);
    send_bit(st1);
    if (has_st2) send_bit(st2);
    signal_in = 1'b1;
  endtask

  initial begin
    int         base;
    int         v0;
    logic [7:0] pb;

    reset         = 1'b0;
    signal_in     = 1'b1;
    ready_in      = 1'b1;
    prescaler_max = 16'd15;
    parity_mode   = 2'b00;
    stop2         = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_flags", {perr_out, ferr_out, brk_out, ovr_out}, 0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // 8N1 byte, latency from start detection to valid
    base = words.size();
    v0   = vhigh;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clock);
    chk("t1_count", words.size() - base, 1);
    chk("t1_word", get_word(base), mk(8'h55, 0, 0, 0, 0));
    chk("t1_pulse", vhigh - v0, 1);
    chk("t1_latency", t_valid - t_busy, 153);

    // Parity: 0xA3 has four ones
    base        = words.size();
    parity_mode = 2'b01;
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clock);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clock);
    parity_mode = 2'b10;
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clock);
    parity_mode = 2'b00;
    chk("t2_count", words.size() - base, 3);
    chk("t2_even_bad", get_word(base), mk(8'hA3, 1, 0, 0, 0));
    chk("t2_even_ok", get_word(base + 1), mk(8'hA3, 0, 0, 0, 0));
    chk("t2_odd_ok", get_word(base + 2), mk(8'hA3, 0, 0, 0, 0));

    // False start: 3-clock glitch
    base      = words.size();
    signal_in = 1'b0;
    repeat (3) @(negedge clock);
    signal_in = 1'b1;
    repeat (2) @(negedge clock);
    chk("t3_busy_on", busy_out, 1);
    repeat (15) @(negedge clock);
    chk("t3_busy_off", busy_out, 0);
    repeat (20) @(negedge clock);
    chk("t3_count", words.size() - base, 0);

    // Break of 12 bit times, then a normal frame
    base      = words.size();
    signal_in = 1'b0;
    repeat (12 * BIT) @(negedge clock);
    signal_in = 1'b1;
    repeat (3 * BIT) @(negedge clock);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clock);
    chk("t4_count", words.size() - base, 2);
    chk("t4_break", get_word(base), mk(8'h00, 0, 1, 1, 0));
    chk("t4_after", get_word(base + 1), mk(8'h0F, 0, 0, 0, 0));

    // Overrun: second frame dropped while the first is held
    ready_in = 1'b0;
    base     = words.size();
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clock);
    chk("t5_held_valid", valid_out, 1);
    chk("t5_held_data", data_out, 8'h11);
    chk("t5_held_ovr", ovr_out, 1);
    ready_in = 1'b1;
    @(negedge clock);
    chk("t5_drop_valid", valid_out, 0);
    repeat (60) @(negedge clock);
    chk("t5_count", words.size() - base, 1);
    chk("t5_word", get_word(base), mk(8'h11, 0, 0, 0, 1));

    // Reset mid-frame with a word held
    ready_in = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clock);
    chk("t6_pre_valid", valid_out, 1);
    pb = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(pb[i]);
    signal_in = pb[3];
    repeat (8) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("t6_rst_valid", valid_out, 0);
    chk("t6_rst_data", data_out, 0);
    chk("t6_rst_flags", {perr_out, ferr_out, brk_out, ovr_out}, 0);
    chk("t6_rst_busy", busy_out, 0);
    signal_in = 1'b1;
    ready_in  = 1'b1;
    repeat (3 * BIT) @(negedge clock);
    base = words.size();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clock);
    chk("t6_count", words.size() - base, 1);
    chk("t6_word", get_word(base), mk(8'h3C, 0, 0, 0, 0));

    // Two stop bits: second stop low, then a clean frame
    stop2 = 1'b1;
    base  = words.size();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (40) @(negedge clock);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (40) @(negedge clock);
    stop2 = 1'b0;
    chk("t6_s2_count", words.size() - base, 2);
    chk("t6_s2_ferr", get_word(base), mk(8'h3C, 0, 1, 0, 0));
    chk("t6_s2_ok", get_word(base + 1), mk(8'h81, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
